muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the 64-bit multi-cycle MIPS core.
- Consumes the two register-file read operands (rd1 -> srca, rd2 -> srcb) for MULT/MULTU/DIV/DIVU.
- Holds results in internal HI/LO registers. HI/LO feed the writeback mux back into the register file write-data port for MFHI/MFLO.
- The control FSM stalls on busy.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_signfix.sv | 11 +
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
// Operation and FSM state types plus small op-decoding helpers.
package muldiv_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CNTW  = 7;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic is_div(input op_e op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the core control path and the muldiv unit.
// master drives the request, slave returns status and HI/LO.
interface muldiv_unit_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;

    modport master (
        output start, op, srca, srcb,
        input  busy, done, hi, lo, dbz
    );

    modport slave (
        input  start, op, srca, srcb,
        output busy, done, hi, lo, dbz
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for sign correction of results.
module muldiv_signfix #(
    parameter int W = 64
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO results.
// Define MULDIV_EARLY_EXIT_EN to let multiplies finish once the multiplier runs out of set bits.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);

    state_e           state;
    op_e              op_r;
    logic             sa;
    logic             sb;
    logic             dz;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    op_e              op_in;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign op_in = op_e'(bus.op);
    assign neg_a = is_signed(op_in) & bus.srca[WIDTH-1];
    assign neg_b = is_signed(op_in) & bus.srcb[WIDTH-1];

    muldiv_signfix #(.W(WIDTH)) u_abs_a (
        .neg(neg_a), .din(bus.srca), .dout(abs_a)
    );
    muldiv_signfix #(.W(WIDTH)) u_abs_b (
        .neg(neg_b), .din(bus.srcb), .dout(abs_b)
    );

    // Shift-add step: acc holds the upper product, q the multiplier/lower product.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_acc_n;
    logic [WIDTH-1:0] mul_q_n;

    assign sum       = {1'b0, acc} + ({(WIDTH+1){q[0]}} & {1'b0, d});
    assign mul_acc_n = sum[WIDTH:1];
    assign mul_q_n   = {sum[0], q[WIDTH-1:1]};

    // Restoring step: acc holds the partial remainder, q the dividend/quotient.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_acc_n;
    logic [WIDTH-1:0] div_q_n;

    assign rem_sh    = {acc, q[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, d};
    assign div_ok    = ~diff[WIDTH];
    assign div_acc_n = div_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_q_n   = {q[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
        .neg(sa ^ sb), .din({acc, q}), .dout(prod_fix)
    );
    muldiv_signfix #(.W(WIDTH)) u_fix_quot (
        .neg(sa ^ sb), .din(q), .dout(quot_fix)
    );
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .neg(sa), .din(acc), .dout(rem_fix)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0]   mrem;
    logic [WIDTH-1:0]   mrem_n;
    logic [CNTW-1:0]    shamt;
    logic [2*WIDTH-1:0] early_p;

    assign mrem_n  = mrem >> 1;
    assign shamt   = cnt - CNTW'(1);
    assign early_p = {mul_acc_n, mul_q_n} >> shamt;
`endif

    // Control FSM with registered status and HI/LO outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_r   <= OP_MULTU;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            acc    <= '0;
            q      <= '0;
            d      <= '0;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
            mrem   <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_r   <= op_in;
                        sa     <= neg_a;
                        sb     <= neg_b;
                        acc    <= '0;
                        cnt    <= CNTW'(WIDTH);
                        busy_r <= 1'b1;
                        if (is_div(op_in)) begin
                            d <= abs_b;
                            if (bus.srcb == '0) begin
                                dz    <= 1'b1;
                                q     <= bus.srca;
                                state <= S_FIX;
                            end else begin
                                dz    <= 1'b0;
                                q     <= abs_a;
                                state <= S_RUN;
                            end
                        end else begin
                            d  <= abs_a;
                            q  <= abs_b;
                            dz <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
                            mrem  <= abs_b;
                            state <= (abs_b == '0) ? S_FIX : S_RUN;
`else
                            state <= S_RUN;
`endif
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNTW'(1);
                    if (is_div(op_r)) begin
                        acc <= div_acc_n;
                        q   <= div_q_n;
                    end else begin
                        acc <= mul_acc_n;
                        q   <= mul_q_n;
                    end
                    if (cnt == CNTW'(1)) begin
                        state <= S_FIX;
                    end
`ifdef MULDIV_EARLY_EXIT_EN
                    if (!is_div(op_r)) begin
                        mrem <= mrem_n;
                        if (mrem_n == '0) begin
                            {acc, q} <= early_p;
                            state    <= S_FIX;
                        end
                    end
`endif
                end
                S_FIX: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= S_DONE;
                    if (dz) begin
                        hi_r  <= q;
                        lo_r  <= '1;
                        dbz_r <= 1'b1;
                    end else begin
                        dbz_r <= 1'b0;
                        if (is_div(op_r)) begin
                            hi_r <= rem_fix;
                            lo_r <= quot_fix;
                        end else begin
                            {hi_r, lo_r} <= prod_fix;
                        end
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.dbz  = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(64)) bus ();

    muldiv_unit #(.WIDTH(64), .CNTW(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        int          restart;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mb;
        int          top;
        if (op[1] && b == 64'd0) return 2;
        if (op[1]) return 66;
`ifdef MULDIV_EARLY_EXIT_EN
        mb = (op[0] && b[63]) ? (64'd0 - b) : b;
        if (mb == 64'd0) return 2;
        top = 0;
        for (int i = 0; i < 64; i++) if (mb[i]) top = i;
        return 2 + top + 1;
`else
        mb  = a;
        top = 0;
        return 66 + top + int'(mb[0] & 1'b0);
`endif
    endfunction

    task automatic model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] hi, output logic [63:0] lo, output logic dz);
        logic [127:0] p;
        logic [63:0]  ma, mb, qq, rr;
        logic         na, nb;
        dz = 1'b0;
        if (!op[1]) begin
            if (op[0]) p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
            else       p = {64'd0, a} * {64'd0, b};
            hi = p[127:64];
            lo = p[63:0];
        end else if (b == 64'd0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else begin
            na = op[0] & a[63];
            nb = op[0] & b[63];
            ma = na ? (64'd0 - a) : a;
            mb = nb ? (64'd0 - b) : b;
            qq = ma / mb;
            rr = ma % mb;
            lo = (na ^ nb) ? (64'd0 - qq) : qq;
            hi = na ? (64'd0 - rr) : rr;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int restart_at,
                          output logic [63:0] hi, output logic [63:0] lo, output logic dz,
                          output int lat, output logic busy_bad);
        lat      = -1;
        busy_bad = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == restart_at);
            if (cyc == 1) begin
                bus.srca = ~a;
                bus.srcb = b ^ 64'h5555;
            end
            if (cyc == restart_at) begin
                bus.op   = 2'b11;
                bus.srca = 64'd77;
                bus.srcb = 64'd0;
            end
            if (bus.done) begin
                lat = cyc;
                if (bus.busy) busy_bad = 1'b1;
                break;
            end
            if (!bus.busy) busy_bad = 1'b1;
        end
        hi = bus.hi;
        lo = bus.lo;
        dz = bus.dbz;
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.done || bus.busy) busy_bad = 1'b1;
    endtask

    task automatic do_vec(input string name, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] ehi, input logic [63:0] elo, input logic edz,
                          input int restart_at);
        logic [63:0] hi, lo;
        logic        dz, bb;
        int          lat, extra;
        run_op(op, a, b, restart_at, hi, lo, dz, lat, bb);
        chk({name, " lat"}, 64'(lat), 64'(exp_lat(op, a, b)));
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
        chk({name, " dbz"}, {63'd0, dz}, {63'd0, edz});
        chk({name, " busy"}, {63'd0, bb}, 64'd0);
        if (restart_at != 0) begin
            extra = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (bus.done || bus.busy) extra++;
            end
            chk({name, " extra_done"}, 64'(extra), 64'd0);
            chk({name, " lo_hold"}, bus.lo, elo);
        end
    endtask

    function automatic logic [63:0] rnd_operand();
        unique case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    vec_t tbl[9];

    initial begin
        logic [63:0] mhi, mlo;
        logic        mdz;
        logic [1:0]  rop;
        logic [63:0] ra, rb;

        tbl[0] = '{2'b00, 64'd6, 64'd7, 64'd0, 64'd42, 1'b0, 0};
        tbl[1] = '{2'b01, -64'sd3, 64'd5, '1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 0};
        tbl[2] = '{2'b10, 64'd100, 64'd7, 64'd2, 64'd14, 1'b0, 0};
        tbl[3] = '{2'b11, -64'sd7, 64'd2, '1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0};
        tbl[4] = '{2'b10, 64'h1234, 64'd0, 64'h1234, '1, 1'b1, 0};
        tbl[5] = '{2'b10, 64'd9, 64'd3, 64'd0, 64'd3, 1'b0, 0};
        tbl[6] = '{2'b00, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 10};
        tbl[7] = '{2'b01, 64'd12, -64'sd4, '1, 64'hFFFF_FFFF_FFFF_FFD0, 1'b0, 66};
        tbl[8] = '{2'b11, 64'h8000_0000_0000_0000, '1, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 0};

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = 64'd0;
        bus.srcb  = 64'd0;

        repeat (3) @(negedge clk);
        chk("rst busy", {63'd0, bus.busy}, 64'd0);
        chk("rst done", {63'd0, bus.done}, 64'd0);
        chk("rst dbz", {63'd0, bus.dbz}, 64'd0);
        chk("rst hi", bus.hi, 64'd0);
        chk("rst lo", bus.lo, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_vec($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].restart);
        end

        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.srca  = 64'd5;
        bus.srcb  = 64'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_rst busy", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst done", {63'd0, bus.done}, 64'd0);
        chk("midrst hi", bus.hi, 64'd0);
        chk("midrst lo", bus.lo, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_vec("after_rst", 2'b00, 64'd5, 64'd5, 64'd0, 64'd25, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = rnd_operand();
            rb  = rnd_operand();
            model(rop, ra, rb, mhi, mlo, mdz);
            do_vec($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, mhi, mlo, mdz, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
